// File: rtl/control_sequencer_pkg.sv
// Shared types for the hardwired control sequencer:
// opcodes, ALU operation codes, FSM states and IR field positions.
package cpu_ctrl_pkg;

    localparam int OPW = 5;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00011;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00100;
    localparam logic [OPW-1:0] OP_ROL  = 5'b00101;
    localparam logic [OPW-1:0] OP_AND  = 5'b00110;
    localparam logic [OPW-1:0] OP_OR   = 5'b00111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01000;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01001;
    localparam logic [OPW-1:0] OP_NEG  = 5'b01010;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01011;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_SHR,
        ALU_SHL,
        ALU_ROR,
        ALU_ROL,
        ALU_AND,
        ALU_OR,
        ALU_MUL,
        ALU_DIV,
        ALU_NEG,
        ALU_NOT,
        ALU_INC
    } alu_op_t;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT,
        S_FAULT
    } state_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    is_binary;
        logic    is_unary;
        logic    is_muldiv;
        logic    is_halt;
        logic    is_illegal;
    } dec_t;

    function automatic logic is_active(state_t s);
        return !(s inside {S_RST, S_HALT, S_FAULT});
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the single-bus
// datapath (slave): IR/handshake inputs and all strobes.
interface control_sequencer_if
    import cpu_ctrl_pkg::*;
#(
    parameter int CNTW = 16
);

    logic [31:0]     IR;
    logic            Mem_ready;
    logic            Stop;

    logic            PCout;
    logic            Zhiout;
    logic            Zlowout;
    logic            MDRout;

    logic            MARin;
    logic            PCin;
    logic            MDRin;
    logic            IRin;
    logic            Yin;
    logic            Zin;
    logic            HIin;
    logic            LOin;

    logic            IncPC;
    logic            Read;

    logic            Gra;
    logic            Grb;
    logic            Grc;
    logic            Rin;
    logic            Rout;

    alu_op_t         alu_op;
    logic            Run;
    logic            Illegal;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, Zhiout, Zlowout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read,
        output Gra, Grb, Grc, Rin, Rout,
        output alu_op, Run, Illegal, instr_count
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, Zhiout, Zlowout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read,
        input  Gra, Grb, Grc, Rin, Rout,
        input  alu_op, Run, Illegal, instr_count
    );

endinterface

// File: rtl/control_sequencer_op_decode.sv
// Opcode classifier: maps IR[31:27] to an ALU op and an
// instruction class that steers the T3..T6 sequence.
module op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output dec_t           dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_NOP;
        unique case (opcode)
            OP_ADD: begin
                dec.alu_op    = ALU_ADD;
                dec.is_binary = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op    = ALU_SUB;
                dec.is_binary = 1'b1;
            end
            OP_SHR: begin
                dec.alu_op    = ALU_SHR;
                dec.is_binary = 1'b1;
            end
            OP_SHL: begin
                dec.alu_op    = ALU_SHL;
                dec.is_binary = 1'b1;
            end
            OP_ROR: begin
                dec.alu_op    = ALU_ROR;
                dec.is_binary = 1'b1;
            end
            OP_ROL: begin
                dec.alu_op    = ALU_ROL;
                dec.is_binary = 1'b1;
            end
            OP_AND: begin
                dec.alu_op    = ALU_AND;
                dec.is_binary = 1'b1;
            end
            OP_OR: begin
                dec.alu_op    = ALU_OR;
                dec.is_binary = 1'b1;
            end
            OP_MUL: begin
                dec.alu_op    = ALU_MUL;
                dec.is_binary = 1'b1;
                dec.is_muldiv = 1'b1;
            end
            OP_DIV: begin
                dec.alu_op    = ALU_DIV;
                dec.is_binary = 1'b1;
                dec.is_muldiv = 1'b1;
            end
            OP_NEG: begin
                dec.alu_op   = ALU_NEG;
                dec.is_unary = 1'b1;
            end
            OP_NOT: begin
                dec.alu_op   = ALU_NOT;
                dec.is_unary = 1'b1;
            end
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute sequencer for the single-bus datapath;
// one micro-step per clock, strobes decoded from state and opcode.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW        = 5,
    parameter int CNTW       = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master ctrl
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);

    state_t          state;
    state_t          retire_next;
    logic [WW-1:0]   wait_cnt;
    logic [CNTW-1:0] count;
    logic [OPW-1:0]  opcode;
    logic            retire;
    logic            unused_ir;
    dec_t            dec;

    assign opcode    = ctrl.IR[IR_OP_HI -: OPW];
    assign unused_ir = ^ctrl.IR[IR_OP_LO-1:0];

    op_decode u_dec (
        .opcode (opcode),
        .dec    (dec)
    );

    assign retire = (state == S_T5 && !dec.is_muldiv)
                 || (state == S_T6);

    assign retire_next = ctrl.Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= S_RST;
            wait_cnt <= '0;
            count    <= '0;
        end else begin
            unique case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1:  state <= ctrl.Mem_ready ? S_T2 : S_T1W;
                S_T1W: begin
                    if (ctrl.Mem_ready) begin
                        state    <= S_T2;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
                        state    <= S_FAULT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    unique case (1'b1)
                        dec.is_binary: state <= S_T4;
                        dec.is_unary:  state <= S_T5;
                        dec.is_halt:   state <= S_HALT;
                        default:       state <= S_FAULT;
                    endcase
                end
                S_T4: state <= S_T5;
                S_T5: state <= dec.is_muldiv ? S_T6 : retire_next;
                S_T6: state <= retire_next;
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
            if (retire) begin
                count <= count + 1'b1;
            end
        end
    end

    // Strobes depend only on state and IR opcode; never on Mem_ready/Stop.
    always_comb begin
        ctrl.PCout   = 1'b0;
        ctrl.Zhiout  = 1'b0;
        ctrl.Zlowout = 1'b0;
        ctrl.MDRout  = 1'b0;
        ctrl.MARin   = 1'b0;
        ctrl.PCin    = 1'b0;
        ctrl.MDRin   = 1'b0;
        ctrl.IRin    = 1'b0;
        ctrl.Yin     = 1'b0;
        ctrl.Zin     = 1'b0;
        ctrl.HIin    = 1'b0;
        ctrl.LOin    = 1'b0;
        ctrl.IncPC   = 1'b0;
        ctrl.Read    = 1'b0;
        ctrl.Gra     = 1'b0;
        ctrl.Grb     = 1'b0;
        ctrl.Grc     = 1'b0;
        ctrl.Rin     = 1'b0;
        ctrl.Rout    = 1'b0;
        ctrl.alu_op  = ALU_NOP;
        unique case (state)
            S_T0: begin
                ctrl.PCout  = 1'b1;
                ctrl.MARin  = 1'b1;
                ctrl.IncPC  = 1'b1;
                ctrl.Zin    = 1'b1;
                ctrl.alu_op = ALU_INC;
            end
            S_T1: begin
                ctrl.Zlowout = 1'b1;
                ctrl.PCin    = 1'b1;
                ctrl.Read    = 1'b1;
                ctrl.MDRin   = 1'b1;
            end
            S_T1W: begin
                ctrl.Read  = 1'b1;
                ctrl.MDRin = 1'b1;
            end
            S_T2: begin
                ctrl.MDRout = 1'b1;
                ctrl.IRin   = 1'b1;
            end
            S_T3: begin
                if (dec.is_binary) begin
                    ctrl.Grb  = 1'b1;
                    ctrl.Rout = 1'b1;
                    ctrl.Yin  = 1'b1;
                end else if (dec.is_unary) begin
                    ctrl.Grb    = 1'b1;
                    ctrl.Rout   = 1'b1;
                    ctrl.Zin    = 1'b1;
                    ctrl.alu_op = dec.alu_op;
                end
            end
            S_T4: begin
                ctrl.Grc    = 1'b1;
                ctrl.Rout   = 1'b1;
                ctrl.Zin    = 1'b1;
                ctrl.alu_op = dec.alu_op;
            end
            S_T5: begin
                ctrl.Zlowout = 1'b1;
                if (dec.is_muldiv) begin
                    ctrl.LOin = 1'b1;
                end else begin
                    ctrl.Gra = 1'b1;
                    ctrl.Rin = 1'b1;
                end
            end
            S_T6: begin
                ctrl.Zhiout = 1'b1;
                ctrl.HIin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.Run         = is_active(state);
    assign ctrl.Illegal     = (state == S_FAULT);
    assign ctrl.instr_count = count;

endmodule
